// File: rtl/filter_sched_if.sv
// Scan-position, button and control-output bundle between the VGA front end and the filter scheduler.
// master drives position/buttons; slave (the scheduler) drives the active settings and strobes.
interface filter_sched_if;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       btn_mode;
    logic       btn_color;
    logic       btn_thr_up;
    logic       btn_thr_dn;
    logic [2:0] filter_sel;
    logic [2:0] color_type;
    logic [3:0] threshold;
    logic       line_sel;
    logic       win_valid;
    logic       frame_start;
    logic       line_start;
    logic       pending;

    modport master (
        output pos_x, pos_y, btn_mode, btn_color, btn_thr_up, btn_thr_dn,
        input  filter_sel, color_type, threshold, line_sel, win_valid,
               frame_start, line_start, pending
    );

    modport slave (
        input  pos_x, pos_y, btn_mode, btn_color, btn_thr_up, btn_thr_dn,
        output filter_sel, color_type, threshold, line_sel, win_valid,
               frame_start, line_start, pending
    );
endinterface

// File: rtl/filter_sched.sv
// Filter setting scheduler: stages button changes, commits them only at frame start,
// then holds the window invalid while the line buffers refill.
//
// state | meaning
// RUN   | staged settings equal active ones, nothing to commit
// PEND  | staged settings changed, waiting for the next frame start to commit
// FLUSH | settings just committed, counting line starts while line buffers refill
module filter_sched #(
    parameter int         H_ACTIVE    = 640,
    parameter int         V_ACTIVE    = 480,
    parameter int         NUM_MODES   = 4,
    parameter logic [3:0] THR_DEFAULT = 4'd4,
    parameter logic [3:0] THR_MIN     = 4'd1,
    parameter logic [3:0] THR_MAX     = 4'd14,
    parameter int         FLUSH_LINES = 2
) (
    input logic           vga_clk,
    input logic           rst,
    filter_sched_if.slave bus
);
    localparam int            FW          = $clog2(FLUSH_LINES + 1);
    localparam logic [2:0]    COLOR_BLACK = 3'b001;
    localparam logic [2:0]    COLOR_WHITE = 3'b010;
    localparam logic [2:0]    MODE_LAST   = 3'(NUM_MODES - 1);
    localparam logic [9:0]    H_LIM       = 10'(H_ACTIVE);
    localparam logic [9:0]    V_LIM       = 10'(V_ACTIVE);
    localparam logic [FW-1:0] FLUSH_LOAD  = FW'(FLUSH_LINES);
    localparam logic [FW-1:0] FLUSH_ONE   = FW'(1);

    typedef enum logic [1:0] {RUN, PEND, FLUSH} state_t;

    state_t        state;
    logic [FW-1:0] flush_cnt;

    logic [9:0] px_q;
    logic [9:0] py_q;

    logic [2:0] stg_mode;
    logic [2:0] stg_color;
    logic [3:0] stg_thr;
    logic [2:0] act_mode;
    logic [2:0] act_color;
    logic [3:0] act_thr;

    logic [2:0] nxt_mode;
    logic [2:0] nxt_color;
    logic [3:0] nxt_thr;

    logic frame_hit;
    logic line_hit;
    logic in_win;
    logic stg_change;
    logic nxt_differs;

    logic line_sel_q;
    logic win_valid_q;
    logic frame_start_q;
    logic line_start_q;
    logic pending_q;

    always_comb begin
        frame_hit = (bus.pos_x == 10'd0) && (bus.pos_y == 10'd0) &&
                    ((px_q != 10'd0) || (py_q != 10'd0));
        line_hit  = ((bus.pos_x == 10'd0) && (px_q != 10'd0)) || frame_hit;
        in_win    = (bus.pos_x >= 10'd2) && (bus.pos_y >= 10'd2) &&
                    (bus.pos_x < H_LIM) && (bus.pos_y < V_LIM);
    end

    // Next staged values; simultaneous up/down cancels without blocking the other buttons.
    always_comb begin
        nxt_mode  = stg_mode;
        nxt_color = stg_color;
        nxt_thr   = stg_thr;
        if (bus.btn_mode) begin
            nxt_mode = (stg_mode >= MODE_LAST) ? 3'd0 : stg_mode + 3'd1;
        end
        if (bus.btn_color) begin
            nxt_color = (stg_color == COLOR_BLACK) ? COLOR_WHITE : COLOR_BLACK;
        end
        if (bus.btn_thr_up && !bus.btn_thr_dn) begin
            nxt_thr = (stg_thr >= THR_MAX) ? stg_thr : stg_thr + 4'd1;
        end else if (bus.btn_thr_dn && !bus.btn_thr_up) begin
            nxt_thr = (stg_thr <= THR_MIN) ? stg_thr : stg_thr - 4'd1;
        end
        stg_change  = {nxt_mode, nxt_color, nxt_thr} != {stg_mode, stg_color, stg_thr};
        nxt_differs = {nxt_mode, nxt_color, nxt_thr} != {act_mode, act_color, act_thr};
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            px_q          <= 10'h3FF;
            py_q          <= 10'h3FF;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            line_sel_q    <= 1'b0;
        end else begin
            px_q          <= bus.pos_x;
            py_q          <= bus.pos_y;
            frame_start_q <= frame_hit;
            line_start_q  <= line_hit;
            if (frame_hit) begin
                line_sel_q <= 1'b0;
            end else if (line_hit) begin
                line_sel_q <= ~line_sel_q;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            state       <= RUN;
            flush_cnt   <= '0;
            pending_q   <= 1'b0;
            win_valid_q <= 1'b0;
            stg_mode    <= 3'd0;
            stg_color   <= COLOR_BLACK;
            stg_thr     <= THR_DEFAULT;
            act_mode    <= 3'd0;
            act_color   <= COLOR_BLACK;
            act_thr     <= THR_DEFAULT;
        end else begin
            stg_mode    <= nxt_mode;
            stg_color   <= nxt_color;
            stg_thr     <= nxt_thr;
            win_valid_q <= in_win && (state != FLUSH);
            case (state)
                RUN: begin
                    if (stg_change) begin
                        state     <= PEND;
                        pending_q <= 1'b1;
                    end
                end
                PEND: begin
                    // Commit takes the pre-pulse staging; a pulse this cycle stays staged.
                    if (frame_hit) begin
                        act_mode  <= stg_mode;
                        act_color <= stg_color;
                        act_thr   <= stg_thr;
                        flush_cnt <= FLUSH_LOAD;
                        state     <= FLUSH;
                        pending_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (line_start_q) begin
                        if (flush_cnt <= FLUSH_ONE) begin
                            flush_cnt <= '0;
                            state     <= nxt_differs ? PEND : RUN;
                            pending_q <= nxt_differs;
                        end else begin
                            flush_cnt <= flush_cnt - FLUSH_ONE;
                        end
                    end
                end
                default: begin
                    state     <= RUN;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.filter_sel  = act_mode;
    assign bus.color_type  = act_color;
    assign bus.threshold   = act_thr;
    assign bus.line_sel    = line_sel_q;
    assign bus.win_valid   = win_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.line_start  = line_start_q;
    assign bus.pending     = pending_q;
endmodule

// File: tb/tb_filter_sched.sv
// Directed bench for filter_sched on a shrunken 10x8 raster (8x6 active).
module tb_filter_sched;
    localparam int HA = 8;
    localparam int VA = 6;
    localparam int HT = 10;
    localparam int VT = 8;

    logic clk = 1'b0;
    logic rst;
    filter_sched_if bus();

    filter_sched #(.H_ACTIVE(HA), .V_ACTIVE(VA)) dut (
        .vga_clk(clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int x     = 0;
    int y     = 0;

    typedef struct {
        int n_mode;
        int n_color;
        int n_up;
        int n_dn;
        int n_both;
        int both_mode;
        int exp_pend;
        int exp_filter;
        int exp_color;
        int exp_thr;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_pos();
        bus.pos_x = 10'(x);
        bus.pos_y = 10'(y);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        bus.btn_mode   = 1'b0;
        bus.btn_color  = 1'b0;
        bus.btn_thr_up = 1'b0;
        bus.btn_thr_dn = 1'b0;
        x++;
        if (x == HT) begin
            x = 0;
            y++;
            if (y == VT) y = 0;
        end
        apply_pos();
    endtask

    task automatic goto_pos(input int xt, input int yt);
        int n = 0;
        while ((x != xt || y != yt) && n < 200) begin
            tick();
            n++;
        end
        check("goto_bound", (x == xt && y == yt) ? 1 : 0, 1);
    endtask

    task automatic pulse(input logic m, input logic c, input logic u, input logic d);
        bus.btn_mode   = m;
        bus.btn_color  = c;
        bus.btn_thr_up = u;
        bus.btn_thr_dn = d;
        tick();
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_filter"}, int'(bus.filter_sel), 0);
        check({tag, "_color"}, int'(bus.color_type), 1);
        check({tag, "_thr"}, int'(bus.threshold), 4);
        check({tag, "_pending"}, int'(bus.pending), 0);
        check({tag, "_line_sel"}, int'(bus.line_sel), 0);
        check({tag, "_win_valid"}, int'(bus.win_valid), 0);
        check({tag, "_frame_start"}, int'(bus.frame_start), 0);
        check({tag, "_line_start"}, int'(bus.line_start), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_f;
        int prev_c;
        int prev_t;
        int sx;
        int sy;

        //            mode col up  dn both bm pend f  c  t
        vecs[0] = '{5, 0, 0,  0,  0, 0, 1, 1, 1, 4};
        vecs[1] = '{0, 0, 12, 0,  0, 0, 1, 1, 1, 14};
        vecs[2] = '{0, 0, 0,  0,  1, 0, 0, 1, 1, 14};
        vecs[3] = '{0, 0, 0,  15, 0, 0, 1, 1, 1, 1};
        vecs[4] = '{3, 1, 0,  0,  0, 0, 1, 0, 2, 1};
        vecs[5] = '{0, 2, 0,  0,  0, 0, 1, 0, 2, 1};
        vecs[6] = '{4, 0, 0,  0,  0, 0, 1, 0, 2, 1};
        vecs[7] = '{0, 0, 0,  0,  2, 1, 1, 2, 2, 1};
        vecs[8] = '{0, 1, 1,  0,  0, 0, 1, 2, 1, 2};

        rst            = 1'b1;
        bus.btn_mode   = 1'b0;
        bus.btn_color  = 1'b0;
        bus.btn_thr_up = 1'b0;
        bus.btn_thr_dn = 1'b0;
        x = 5;
        y = 3;
        apply_pos();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst0");

        rst = 1'b0;
        x = 0;
        y = 0;
        apply_pos();
        tick();
        check("first_frame_start", int'(bus.frame_start), 1);
        check("first_line_start", int'(bus.line_start), 1);
        check("first_line_sel", int'(bus.line_sel), 0);
        check("first_thr", int'(bus.threshold), 4);
        check("first_pending", int'(bus.pending), 0);

        prev_f = 0;
        prev_c = 1;
        prev_t = 4;
        for (int i = 0; i < 9; i++) begin
            goto_pos(1, 3);
            repeat (vecs[i].n_mode) pulse(1'b1, 1'b0, 1'b0, 1'b0);
            repeat (vecs[i].n_color) pulse(1'b0, 1'b1, 1'b0, 1'b0);
            repeat (vecs[i].n_up) pulse(1'b0, 1'b0, 1'b1, 1'b0);
            repeat (vecs[i].n_dn) pulse(1'b0, 1'b0, 1'b0, 1'b1);
            repeat (vecs[i].n_both) pulse(vecs[i].both_mode != 0, 1'b0, 1'b1, 1'b1);
            check($sformatf("v%0d_pending", i), int'(bus.pending), vecs[i].exp_pend);
            check($sformatf("v%0d_hold_filter", i), int'(bus.filter_sel), prev_f);
            check($sformatf("v%0d_hold_color", i), int'(bus.color_type), prev_c);
            check($sformatf("v%0d_hold_thr", i), int'(bus.threshold), prev_t);
            goto_pos(0, 0);
            tick();
            check($sformatf("v%0d_frame_start", i), int'(bus.frame_start), 1);
            check($sformatf("v%0d_filter", i), int'(bus.filter_sel), vecs[i].exp_filter);
            check($sformatf("v%0d_color", i), int'(bus.color_type), vecs[i].exp_color);
            check($sformatf("v%0d_thr", i), int'(bus.threshold), vecs[i].exp_thr);
            check($sformatf("v%0d_pending_clr", i), int'(bus.pending), 0);
            prev_f = vecs[i].exp_filter;
            prev_c = vecs[i].exp_color;
            prev_t = vecs[i].exp_thr;
        end

        // Full frame after a commit: strobes, window and line_sel against the raster.
        goto_pos(1, 3);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("win_pending", int'(bus.pending), 1);
        goto_pos(0, 0);
        for (int k = 0; k < HT * VT; k++) begin
            sx = x;
            sy = y;
            tick();
            check($sformatf("fs_%0d_%0d", sx, sy), int'(bus.frame_start),
                  (sx == 0 && sy == 0) ? 1 : 0);
            check($sformatf("ls_%0d_%0d", sx, sy), int'(bus.line_start), (sx == 0) ? 1 : 0);
            check($sformatf("win_%0d_%0d", sx, sy), int'(bus.win_valid),
                  (sx >= 2 && sy >= 2 && sx < HA && sy < VA) ? 1 : 0);
            if (sx == 0) begin
                check($sformatf("line_sel_%0d", sy), int'(bus.line_sel), sy % 2);
            end
            if (k == 0) begin
                check("win_commit_thr", int'(bus.threshold), 3);
                check("win_commit_pending", int'(bus.pending), 0);
            end
        end

        // Colour button landing exactly on the commit cycle.
        goto_pos(1, 3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("cc_pending", int'(bus.pending), 1);
        goto_pos(0, 0);
        bus.btn_color = 1'b1;
        tick();
        check("cc_frame_start", int'(bus.frame_start), 1);
        check("cc_filter", int'(bus.filter_sel), 3);
        check("cc_color_held", int'(bus.color_type), 1);
        check("cc_pending_commit", int'(bus.pending), 0);
        goto_pos(1, 3);
        check("cc_pending_after_flush", int'(bus.pending), 1);
        check("cc_color_still", int'(bus.color_type), 1);
        goto_pos(0, 0);
        tick();
        check("cc2_frame_start", int'(bus.frame_start), 1);
        check("cc2_color", int'(bus.color_type), 2);
        check("cc2_filter", int'(bus.filter_sel), 3);
        check("cc2_pending", int'(bus.pending), 0);

        // Reset while changes are pending discards them.
        goto_pos(1, 3);
        repeat (3) pulse(1'b0, 1'b0, 1'b1, 1'b0);
        check("rp_pending", int'(bus.pending), 1);
        check("rp_thr_hold", int'(bus.threshold), 3);
        rst = 1'b1;
        tick();
        tick();
        check_reset_vals("rst1");
        rst = 1'b0;
        goto_pos(0, 0);
        tick();
        check("rp_frame_start", int'(bus.frame_start), 1);
        check("rp_thr", int'(bus.threshold), 4);
        check("rp_filter", int'(bus.filter_sel), 0);
        check("rp_color", int'(bus.color_type), 1);
        check("rp_pending", int'(bus.pending), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
